cim_acc_bank: RTL and testbench
===============================

Name: cim_acc_bank

Overview:
- Next-generation CiM accumulator bank. Each accepted (w, b) beat goes through a shared ALU, then accumulates into one of N_CELL wide accumulator cells.
- Adds the following over the previous cell group:
  - valid/ready input handshake
  - round-robin or addressed cell selection
  - a separate accumulator width
  - a registered ALU stage
  - a streamed, optionally clearing readout (drain)
- Sits between the weight/bias feeder and the result collector inside cim.

Parameters:
- N_CELL, 12, number of accumulator cells (>=2).
- DATA_WIDTH, 32, width of w, b and the ALU result.
- ACC_WIDTH, 40, accumulator and readout width (>= DATA_WIDTH).
- ALU_KIND, `ALU_KIND, ALU operation: 0 = add, 1 = multiply (low DATA_WIDTH bits).
- SEL_MODE, 0, 0 = round-robin write pointer, 1 = cell index taken from in_sel_i.
- IDX_WIDTH (localparam), $clog2(N_CELL).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- clr_i  in  1  synchronous clear of all cells, pointers, pipeline and error flag
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  bank accepts a beat
- in_w_i  in  DATA_WIDTH  weight operand
- in_b_i  in  DATA_WIDTH  bias/second operand
- in_sel_i  in  IDX_WIDTH  target cell; used only when SEL_MODE=1
- rd_start_i  in  1  request drain of all cells
- rd_clear_i  in  1  sampled with rd_start_i; clear each cell as it is read
- out_valid_o  out  1  readout beat valid
- out_ready_i  in  1  downstream accepts readout
- out_data_o  out  ACC_WIDTH  accumulator value
- out_idx_o  out  IDX_WIDTH  index of the cell on out_data_o
- out_last_o  out  1  final cell of the drain (idx N_CELL-1)
- err_o  out  1  sticky: addressed beat had in_sel_i >= N_CELL
- busy_o  out  1  state != ACC, or pipeline stage valid

Behaviour:
- Reset / clr_i values:
  - all cells 0; wr_ptr 0; rd_ptr 0
  - stage valid 0; state ACC; err_o 0
  - out_valid_o 0; in_ready_o 1 after reset
- clr_i behaviour:
  - has priority over everything, in any state
  - aborts a drain and discards any stage beat
  - in_ready_o = 0 while clr_i = 1
- States:
  - ACC: in_ready_o = !clr_i. Handshake = in_valid_i & in_ready_o.
  - FLUSH: in_ready_o = 0. Waits until the stage is empty (at most 1 cycle), then goes to DRAIN.
  - DRAIN: in_ready_o = 0. out_valid_o = 1; out_data_o = cell[rd_ptr] (combinational from the cell).
- ACC: on handshake, the stage registers alu(w, b) and the target index. Target index is wr_ptr (SEL_MODE 0) or in_sel_i (SEL_MODE 1).
- Stage writeback (the following cycle):
  - cell[idx] += sign_extend(stage result) to ACC_WIDTH; accumulation wraps modulo 2^ACC_WIDTH.
  - Latency: beat accepted at cycle t is visible in the cell at t+2.
  - Back-to-back beats to the same cell are accumulated correctly (no forwarding is needed because each beat performs its own read-modify-write at writeback).
- Round-robin: wr_ptr increments on each handshake and wraps from N_CELL-1 to 0.
- Addressed, in_sel_i >= N_CELL: beat is accepted and dropped; err_o is set (sticky until rst or clr_i).
- rd_start_i in ACC:
  - latches rd_clear_i and goes to FLUSH
  - a same-cycle input handshake is still accepted and completes before DRAIN
  - ignored in FLUSH/DRAIN
- DRAIN, on out_valid & out_ready_i:
  - if the latched rd_clear is set, cell[rd_ptr] <= 0
  - rd_ptr increments
  - at rd_ptr = N_CELL-1 (out_last_o = 1): rd_ptr <= 0, state <= ACC
  - wr_ptr is unchanged by a drain.
- Output stability: out_data_o and out_idx_o are held stable while out_valid_o & !out_ready_i.

Optional Feature:
- Macro: CIM_ACC_SAT_EN.
- Defined: writeback uses signed saturating add. Overflow clamps to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1), and sets a per-cell sticky sat bit. An extra output sat_o (1 bit) reports the sat bit of the cell currently on out_data_o. Sat bits clear with the cell (rst, clr_i, clearing drain).
- Not defined: wrap-around add; sat_o port absent.

Decomposition:
- Package cim_pkg:
  - ALU_ADD / ALU_MUL constants
  - SEL_RR / SEL_ADDR constants
  - bank_state_e enum (ACC, FLUSH, DRAIN)
- Sub-module cim_acc_cell: one accumulator with add, clear, and the optional saturation logic.
- The existing alu is reused unchanged.

Test Plan:
- Round-robin, ALU add, N_CELL=4: 8 beats (w=1, b=2) -> every cell = 6; drain yields idx 0..3, each 6; out_last_o only on idx 3.
- Addressed, ALU mul: beats (3,4) and (5,-2) to cell 2 back-to-back -> cell 2 = 2, other cells 0; in_sel_i=7 -> dropped, err_o=1 until clr_i.
- Drain with rd_clear=1 under random out_ready_i stalls -> data stable during stalls; second drain returns all 0; in_ready_o = 0 throughout the drain.
- rd_start_i coincident with an input handshake (w=10, b=0, add) -> the drained value includes +10.
- clr_i mid-drain at rd_ptr=1 -> next cycle state ACC, out_valid_o=0, all cells 0, in_ready_o=1.
- CIM_ACC_SAT_EN, ACC_WIDTH=DATA_WIDTH=8, add: 2 beats (100, 0) into one cell -> value 127, sat_o=1; without the macro -> -56.

Source files
------------

// File: rtl/cim_pkg.sv
// cim_pkg: shared constants and the bank state type for the cim accumulator bank.
// Related optional-feature macro: CIM_ACC_SAT_EN (saturating accumulation, see cim_acc_cell).
package cim_pkg;

  // ALU operation selector values
  localparam int ALU_ADD = 0;
  localparam int ALU_MUL = 1;

  // Cell selection mode values
  localparam int SEL_RR   = 0;
  localparam int SEL_ADDR = 1;

  // Bank control states: accumulate, flush the ALU stage, stream cells out
  typedef enum logic [1:0] {
    ACC   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } bank_state_e;

endpackage

// File: rtl/alu.sv
// alu: shared combinational ALU used in front of the accumulator cells.
// ALU_KIND selects add or multiply; the multiply keeps the low DATA_WIDTH bits.
module alu
  import cim_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ALU_KIND   = ALU_ADD
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  generate
    if (ALU_KIND == ALU_MUL) begin : g_mul
      assign y = a * b;
    end else begin : g_add
      assign y = a + b;
    end
  endgenerate

endmodule

// File: rtl/cim_acc_cell.sv
// cim_acc_cell: one wide accumulator with synchronous clear and add.
// With CIM_ACC_SAT_EN defined the add is a signed saturating add and a
// sticky sat flag records any clamp; otherwise the add wraps.
module cim_acc_cell #(
  parameter int ACC_WIDTH = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 add_en,
  input  logic [ACC_WIDTH-1:0] add_val,
  output logic [ACC_WIDTH-1:0] value
`ifdef CIM_ACC_SAT_EN
  ,
  output logic                 sat
`endif
);

  logic [ACC_WIDTH-1:0] sum;

  assign sum = value + add_val;

`ifdef CIM_ACC_SAT_EN
  localparam logic [ACC_WIDTH-1:0] MAX_POS = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] MAX_NEG = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic                 ovf;
  logic [ACC_WIDTH-1:0] sum_sat;

  // Signed overflow: operands share a sign that the raw sum does not; clamp toward that sign
  always_comb begin
    ovf     = (value[ACC_WIDTH-1] == add_val[ACC_WIDTH-1]) &&
              (sum[ACC_WIDTH-1] != value[ACC_WIDTH-1]);
    sum_sat = sum;
    if (ovf) begin
      sum_sat = value[ACC_WIDTH-1] ? MAX_NEG : MAX_POS;
    end
  end

  // Accumulator and sticky sat flag; clear wins over add
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
      sat   <= 1'b0;
    end else if (add_en) begin
      value <= sum_sat;
      if (ovf) begin
        sat <= 1'b1;
      end
    end
  end
`else
  // Accumulator with wrap-around add; clear wins over add
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
    end else if (add_en) begin
      value <= sum;
    end
  end
`endif

endmodule

// File: rtl/cim_acc_bank.sv
// cim_acc_bank: accumulator bank between the weight/bias feeder and the result collector.
// Accepted (w, b) beats go through the ALU into a one-deep stage register, then
// are added into the selected cell the next cycle. A drain streams every cell out
// in index order, optionally clearing each as it is read.
// Optional-feature macro: CIM_ACC_SAT_EN (saturating cells plus sat_o port).
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high. in_ready_o never depends on in_valid_i; out_valid_o never depends on
// out_ready_i, and out_data_o/out_idx_o hold steady while valid is high and ready low.
`ifndef ALU_KIND
`define ALU_KIND 0
`endif

module cim_acc_bank
  import cim_pkg::*;
#(
  parameter  int N_CELL     = 12,
  parameter  int DATA_WIDTH = 32,
  parameter  int ACC_WIDTH  = 40,
  parameter  int ALU_KIND   = `ALU_KIND,
  parameter  int SEL_MODE   = SEL_RR,
  localparam int IDX_WIDTH  = $clog2(N_CELL)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_w_i,
  input  logic [DATA_WIDTH-1:0] in_b_i,
  input  logic [IDX_WIDTH-1:0]  in_sel_i,
  input  logic                  rd_start_i,
  input  logic                  rd_clear_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ACC_WIDTH-1:0]  out_data_o,
  output logic [IDX_WIDTH-1:0]  out_idx_o,
  output logic                  out_last_o,
  output logic                  err_o,
`ifdef CIM_ACC_SAT_EN
  output logic                  sat_o,
`endif
  output logic                  busy_o
);

  localparam logic [IDX_WIDTH:0]   N_CELL_W = (IDX_WIDTH+1)'(N_CELL);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_CELL - 1);

  bank_state_e state, state_nxt;

  logic [IDX_WIDTH-1:0]  wr_ptr;
  logic [IDX_WIDTH-1:0]  rd_ptr;
  logic [IDX_WIDTH-1:0]  tgt_idx;
  logic                  tgt_ok;
  logic                  hs;
  logic                  drain_hs;
  logic                  rd_last;
  logic                  rd_clear_q;

  logic [DATA_WIDTH-1:0] alu_y;
  logic                  stage_valid;
  logic [DATA_WIDTH-1:0] stage_data;
  logic [IDX_WIDTH-1:0]  stage_idx;
  logic [ACC_WIDTH-1:0]  stage_ext;

  logic [ACC_WIDTH-1:0]  cell_val [N_CELL];
  logic [N_CELL-1:0]     cell_add;
  logic [N_CELL-1:0]     cell_clr;
`ifdef CIM_ACC_SAT_EN
  logic [N_CELL-1:0]     cell_sat;
`endif

  // Handshake and target selection
  assign in_ready_o = (state == ACC) && !clr_i;
  assign hs         = in_valid_i && in_ready_o;
  assign tgt_idx    = (SEL_MODE == SEL_ADDR) ? in_sel_i : wr_ptr;
  assign tgt_ok     = {1'b0, tgt_idx} < N_CELL_W;

  // Readout side: data is read combinationally from the cell under rd_ptr
  assign out_valid_o = (state == DRAIN);
  assign rd_last     = (rd_ptr == LAST_IDX);
  assign drain_hs    = out_valid_o && out_ready_i && !clr_i;
  assign out_data_o  = cell_val[rd_ptr];
  assign out_idx_o   = rd_ptr;
  assign out_last_o  = out_valid_o && rd_last;
`ifdef CIM_ACC_SAT_EN
  assign sat_o       = cell_sat[rd_ptr];
`endif

  assign busy_o    = (state != ACC) || stage_valid;
  assign stage_ext = ACC_WIDTH'($signed(stage_data));

  alu #(
    .DATA_WIDTH(DATA_WIDTH),
    .ALU_KIND  (ALU_KIND)
  ) u_alu (
    .a(in_w_i),
    .b(in_b_i),
    .y(alu_y)
  );

  generate
    for (genvar i = 0; i < N_CELL; i++) begin : g_cell
      assign cell_add[i] = stage_valid && (stage_idx == IDX_WIDTH'(i));
      assign cell_clr[i] = clr_i || (drain_hs && rd_clear_q && (rd_ptr == IDX_WIDTH'(i)));

      cim_acc_cell #(
        .ACC_WIDTH(ACC_WIDTH)
      ) u_cell (
        .clk    (clk),
        .rst    (rst),
        .clr    (cell_clr[i]),
        .add_en (cell_add[i]),
        .add_val(stage_ext),
`ifdef CIM_ACC_SAT_EN
        .sat    (cell_sat[i]),
`endif
        .value  (cell_val[i])
      );
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: clear aborts anything; FLUSH waits for the stage beat to land
  always_comb begin
    state_nxt = state;
    if (clr_i) begin
      state_nxt = ACC;
    end else begin
      case (state)
        ACC:     if (rd_start_i) state_nxt = FLUSH;
        FLUSH:   if (!stage_valid) state_nxt = DRAIN;
        DRAIN:   if (drain_hs && rd_last) state_nxt = ACC;
        default: state_nxt = ACC;
      endcase
    end
  end

  // ALU stage register: holds one accepted beat for writeback next cycle
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      stage_valid <= 1'b0;
      stage_data  <= '0;
      stage_idx   <= '0;
    end else begin
      stage_valid <= hs && tgt_ok;
      if (hs && tgt_ok) begin
        stage_data <= alu_y;
        stage_idx  <= tgt_idx;
      end
    end
  end

  // Round-robin write pointer; untouched by drains and by addressed mode
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wr_ptr <= '0;
    end else if (hs && (SEL_MODE == SEL_RR)) begin
      wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
    end
  end

  // Read pointer walks 0..N_CELL-1 across a drain and returns to 0
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      rd_ptr <= '0;
    end else if (drain_hs) begin
      rd_ptr <= rd_last ? '0 : rd_ptr + 1'b1;
    end
  end

  // Clear-on-read mode captured when a drain is requested
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      rd_clear_q <= 1'b0;
    end else if ((state == ACC) && rd_start_i) begin
      rd_clear_q <= rd_clear_i;
    end
  end

  // Sticky error for an addressed beat whose index has no cell
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      err_o <= 1'b0;
    end else if (hs && !tgt_ok) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cim_acc_bank.sv
// tb_cim_acc_bank: self-checking bench for cim_acc_bank.
// Instance A: 4 cells, add, round-robin, 32/40 bits (directed + random vs. model).
// Instance B: 6 cells, multiply, addressed, 8/8 bits (table-driven beats).
// Instance C: 2 cells, add, addressed, 8/8 bits (overflow behaviour).
module tb_cim_acc_bank;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- instance A signals ----------------
  logic        a_clr, a_in_valid, a_in_ready, a_rd_start, a_rd_clear;
  logic        a_out_valid, a_out_ready, a_out_last, a_err, a_busy;
  logic [31:0] a_w, a_b;
  logic [1:0]  a_sel, a_out_idx;
  logic [39:0] a_out_data;
  // ---------------- instance B signals ----------------
  logic        b_clr, b_in_valid, b_in_ready, b_rd_start, b_rd_clear;
  logic        b_out_valid, b_out_ready, b_out_last, b_err, b_busy;
  logic [7:0]  b_w, b_b, b_out_data;
  logic [2:0]  b_sel, b_out_idx;
  // ---------------- instance C signals ----------------
  logic        c_clr, c_in_valid, c_in_ready, c_rd_start, c_rd_clear;
  logic        c_out_valid, c_out_ready, c_out_last, c_err, c_busy;
  logic [7:0]  c_w, c_b, c_out_data;
  logic [0:0]  c_sel, c_out_idx;
`ifdef CIM_ACC_SAT_EN
  logic        a_sat, b_sat, c_sat;
`endif

  cim_acc_bank #(.N_CELL(4), .DATA_WIDTH(32), .ACC_WIDTH(40), .ALU_KIND(0), .SEL_MODE(0)) u_a (
    .clk(clk), .rst(rst), .clr_i(a_clr), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .in_w_i(a_w), .in_b_i(a_b), .in_sel_i(a_sel), .rd_start_i(a_rd_start), .rd_clear_i(a_rd_clear),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
    .out_idx_o(a_out_idx), .out_last_o(a_out_last), .err_o(a_err),
`ifdef CIM_ACC_SAT_EN
    .sat_o(a_sat),
`endif
    .busy_o(a_busy));

  cim_acc_bank #(.N_CELL(6), .DATA_WIDTH(8), .ACC_WIDTH(8), .ALU_KIND(1), .SEL_MODE(1)) u_b (
    .clk(clk), .rst(rst), .clr_i(b_clr), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .in_w_i(b_w), .in_b_i(b_b), .in_sel_i(b_sel), .rd_start_i(b_rd_start), .rd_clear_i(b_rd_clear),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .out_idx_o(b_out_idx), .out_last_o(b_out_last), .err_o(b_err),
`ifdef CIM_ACC_SAT_EN
    .sat_o(b_sat),
`endif
    .busy_o(b_busy));

  cim_acc_bank #(.N_CELL(2), .DATA_WIDTH(8), .ACC_WIDTH(8), .ALU_KIND(0), .SEL_MODE(1)) u_c (
    .clk(clk), .rst(rst), .clr_i(c_clr), .in_valid_i(c_in_valid), .in_ready_o(c_in_ready),
    .in_w_i(c_w), .in_b_i(c_b), .in_sel_i(c_sel), .rd_start_i(c_rd_start), .rd_clear_i(c_rd_clear),
    .out_valid_o(c_out_valid), .out_ready_i(c_out_ready), .out_data_o(c_out_data),
    .out_idx_o(c_out_idx), .out_last_o(c_out_last), .err_o(c_err),
`ifdef CIM_ACC_SAT_EN
    .sat_o(c_sat),
`endif
    .busy_o(c_busy));

  // ---------------- scoreboard / model state ----------------
  logic [39:0] a_exp [4];
  logic [39:0] m_cell [4];
  int          m_wr;
  int          m_rd;
  logic [39:0] exp_q [$];
  bit          held;
  logic [39:0] held_d;
  logic [1:0]  held_i;

  typedef struct {
    logic [7:0] w;
    logic [7:0] b;
    logic [2:0] sel;
    logic       exp_err;
  } b_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Request a drain of A, optionally with a same-cycle (10, 0) beat
  task automatic a_start(input bit clr, input bit beat);
    @(posedge clk); #1;
    a_rd_start = 1'b1; a_rd_clear = clr;
    a_in_valid = beat; a_w = 32'd10; a_b = 32'd0;
    @(negedge clk);
    check("a_start_ready", a_in_ready, 1);
    @(posedge clk); #1;
    a_rd_start = 1'b0; a_in_valid = 1'b0;
  endtask

  // Collect one full drain of A against a_exp, optionally with random stalls
  task automatic a_collect(input bit stall);
    int k = 0;
    int budget = 0;
    bit hv = 0;
    logic [39:0] hd;
    logic [1:0]  hi;
    while (k < 4 && budget < 200) begin
      @(posedge clk); #1;
      a_out_ready = stall ? ($urandom_range(0, 2) == 0 ? 1'b0 : 1'b1) : 1'b1;
      @(negedge clk);
      budget++;
      if (a_out_valid) begin
        check("a_drain_in_ready", a_in_ready, 0);
        if (hv) begin
          check("a_stall_data", a_out_data, hd);
          check("a_stall_idx", a_out_idx, hi);
        end
        if (a_out_ready) begin
          check("a_drain_idx", a_out_idx, k);
          check("a_drain_data", a_out_data, a_exp[k]);
          check("a_drain_last", a_out_last, (k == 3));
          k++;
          hv = 0;
        end else begin
          hv = 1; hd = a_out_data; hi = a_out_idx;
        end
      end
    end
    if (k < 4) check("a_drain_timeout", k, 4);
    @(posedge clk); #1;
    a_out_ready = 1'b0;
  endtask

  // One random cycle on A, checked against the cell-array model
  task automatic a_rand_cycle(input bit quiet);
    logic [31:0] s;
    @(posedge clk); #1;
    a_in_valid  = quiet ? 1'b0 : ($urandom_range(0, 3) != 0);
    a_w         = $urandom;
    a_b         = $urandom;
    a_rd_start  = quiet ? 1'b0 : ($urandom_range(0, 50) == 0);
    a_rd_clear  = $urandom_range(0, 1);
    a_out_ready = quiet ? 1'b1 : ($urandom_range(0, 3) != 0);
    @(negedge clk);
    if (a_in_valid && a_in_ready) begin
      s = a_w + a_b;
      m_cell[m_wr] = m_cell[m_wr] + {{8{s[31]}}, s};
      m_wr = (m_wr + 1) % 4;
    end
    if (a_rd_start && a_in_ready) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(m_cell[k]);
      if (a_rd_clear) for (int k = 0; k < 4; k++) m_cell[k] = '0;
    end
    if (a_out_valid) begin
      check("a_rand_in_ready", a_in_ready, 0);
      if (held) check("a_rand_stall_data", {a_out_idx, a_out_data}, {held_i, held_d});
      if (a_out_ready) begin
        held = 0;
        if (exp_q.size() == 0) begin
          check("a_rand_unexpected_beat", 1, 0);
        end else begin
          check("a_rand_data", a_out_data, exp_q.pop_front());
          check("a_rand_idx", a_out_idx, m_rd);
          check("a_rand_last", a_out_last, (m_rd == 3));
          m_rd = (m_rd + 1) % 4;
        end
      end else begin
        held = 1; held_d = a_out_data; held_i = a_out_idx;
      end
    end else begin
      held = 0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    b_vec_t b_tbl [3];
    logic [7:0] b_exp [6];
    int k;

    // ---------------- clock / reset ----------------
    rst = 1'b1;
    {a_clr, a_in_valid, a_rd_start, a_rd_clear, a_out_ready, a_w, a_b, a_sel} = '0;
    {b_clr, b_in_valid, b_rd_start, b_rd_clear, b_out_ready, b_w, b_b, b_sel} = '0;
    {c_clr, c_in_valid, c_rd_start, c_rd_clear, c_out_ready, c_w, c_b, c_sel} = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_a_in_ready", a_in_ready, 1);
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_err", a_err, 0);
    check("rst_b_err", b_err, 0);
    check("rst_c_in_ready", c_in_ready, 1);

    // ---------------- A: 8 round-robin beats (1,2) -> each cell 6 ----------------
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      a_in_valid = 1'b1; a_w = 32'd1; a_b = 32'd2;
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    check("a_busy_after_beats", a_busy, 1);
    for (int i = 0; i < 4; i++) a_exp[i] = 40'd6;
    a_start(1'b0, 1'b0);
    a_collect(1'b0);
    // Clearing drain under random stalls, then all zero
    a_start(1'b1, 1'b0);
    a_collect(1'b1);
    for (int i = 0; i < 4; i++) a_exp[i] = 40'd0;
    a_start(1'b0, 1'b0);
    a_collect(1'b1);

    // ---------------- A: rd_start with coincident beat (10,0) ----------------
    a_exp[0] = 40'd10;
    a_start(1'b1, 1'b1);
    a_collect(1'b0);

    // ---------------- A: clr_i mid-drain at rd_ptr=1 ----------------
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      a_in_valid = 1'b1; a_w = 32'd5; a_b = 32'd0;
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_start(1'b0, 1'b0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!a_out_valid && k < 20);
    check("a_mid_drain_valid", a_out_valid, 1);
    @(posedge clk); #1 a_out_ready = 1'b1;
    @(posedge clk); #1 a_out_ready = 1'b0;
    @(negedge clk);
    check("a_mid_drain_idx", a_out_idx, 1);
    @(posedge clk); #1 a_clr = 1'b1;
    @(negedge clk);
    check("a_clr_in_ready_low", a_in_ready, 0);
    @(posedge clk); #1 a_clr = 1'b0;
    @(negedge clk);
    check("a_clr_out_valid", a_out_valid, 0);
    check("a_clr_in_ready", a_in_ready, 1);
    check("a_clr_busy", a_busy, 0);
    for (int i = 0; i < 4; i++) a_exp[i] = 40'd0;
    a_start(1'b0, 1'b0);
    a_collect(1'b0);

    // ---------------- A: random stimulus vs. model ----------------
    for (int i = 0; i < 4; i++) m_cell[i] = '0;
    m_wr = 0; m_rd = 0; held = 0;
    for (int cyc = 0; cyc < 1500; cyc++) a_rand_cycle(1'b0);
    for (int cyc = 0; cyc < 40 && (exp_q.size() != 0 || a_out_valid); cyc++) a_rand_cycle(1'b1);
    check("a_rand_queue_empty", exp_q.size(), 0);

    // ---------------- B: table of addressed multiply beats ----------------
    b_tbl[0] = '{w: 8'd3, b: 8'd4,   sel: 3'd2, exp_err: 1'b0};
    b_tbl[1] = '{w: 8'd5, b: 8'hFE,  sel: 3'd2, exp_err: 1'b0};
    b_tbl[2] = '{w: 8'd1, b: 8'd1,   sel: 3'd7, exp_err: 1'b1};
    for (int i = 0; i <= 3; i++) begin
      @(posedge clk); #1;
      if (i < 3) begin
        b_in_valid = 1'b1; b_w = b_tbl[i].w; b_b = b_tbl[i].b; b_sel = b_tbl[i].sel;
      end else begin
        b_in_valid = 1'b0;
      end
      @(negedge clk);
      if (i > 0) check($sformatf("b_err_vec%0d", i - 1), b_err, b_tbl[i-1].exp_err);
    end
    b_exp = '{8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0};
    @(posedge clk); #1;
    b_rd_start = 1'b1; b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_rd_start = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 40 && k < 6; cyc++) begin
      @(negedge clk);
      if (b_out_valid) begin
        check("b_drain_idx", b_out_idx, k);
        check("b_drain_data", b_out_data, b_exp[k]);
        check("b_drain_last", b_out_last, (k == 5));
        k++;
      end
    end
    if (k < 6) check("b_drain_timeout", k, 6);
    @(posedge clk); #1 b_out_ready = 1'b0;
    @(negedge clk);
    check("b_err_sticky", b_err, 1);
    @(posedge clk); #1 b_clr = 1'b1;
    @(posedge clk); #1 b_clr = 1'b0;
    @(negedge clk);
    check("b_err_cleared", b_err, 0);

    // ---------------- C: two (100,0) beats into cell 0 ----------------
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      c_in_valid = 1'b1; c_w = 8'd100; c_b = 8'd0; c_sel = 1'b0;
    end
    @(posedge clk); #1;
    c_in_valid = 1'b0; c_rd_start = 1'b1; c_out_ready = 1'b1;
    @(posedge clk); #1;
    c_rd_start = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 20 && k < 2; cyc++) begin
      @(negedge clk);
      if (c_out_valid) begin
        check("c_drain_idx", c_out_idx, k);
        if (k == 0) begin
`ifdef CIM_ACC_SAT_EN
          check("c_sat_value", c_out_data, 8'h7F);
          check("c_sat_flag", c_sat, 1);
`else
          check("c_wrap_value", c_out_data, 8'hC8);
`endif
        end
        k++;
      end
    end
    if (k < 2) check("c_drain_timeout", k, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
